// File: rtl/cordic_share_arbiter.sv
// cordic_share_arbiter
// Shares one CORDIC core among NREQ requesters. A round-robin pick grants one
// request, latches its operand and operation select, runs the core once, and
// returns the result over a valid/ack handshake. A watchdog aborts the run if
// the core never reports ready. Only one job is outstanding at a time.
module cordic_share_arbiter #(
   parameter int NREQ    = 4,
   parameter int W       = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] req_data,
   input  logic [NREQ-1:0]   req_op,
   output logic [NREQ-1:0]   grant,
   output logic [NREQ-1:0]   rsp_valid,
   input  logic [NREQ-1:0]   rsp_ack,
   output logic [W-1:0]      rsp_data,
   output logic              rsp_err,
   output logic              cordic_beg,
   output logic [W-1:0]      cordic_data,
   output logic              cordic_op,
   input  logic              cordic_ready,
   input  logic [W-1:0]      cordic_result,
   output logic              cordic_ack,
   output logic              busy
);

   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNTW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   ptr_q, ptr_d;
   logic [IDXW-1:0]   gIdx_q, gIdx_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]      opnd_q, opnd_d;
   logic              op_q, op_d;
   logic [W-1:0]      rspData_q, rspData_d;
   logic              rspErr_q, rspErr_d;
   logic [NREQ-1:0]   rspValid_q, rspValid_d;

   logic [IDXW-1:0]   pickIdx;
   logic              pickFound;
   logic [NREQ-1:0]   grantVec;
   logic              begComb;
   logic              ackComb;

   // Round-robin search: first asserted request at or above the pointer, wrapping to 0.
   always_comb begin : pickSearch
      int idx;
      pickFound = 1'b0;
      pickIdx   = '0;
      idx       = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!pickFound && req[idx]) begin
            pickFound = 1'b1;
            pickIdx   = IDXW'(idx);
         end
      end
   end

   // Next-state and handshake logic for one arbitrated CORDIC run.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gIdx_d     = gIdx_q;
      cnt_d      = cnt_q;
      opnd_d     = opnd_q;
      op_d       = op_q;
      rspData_d  = rspData_q;
      rspErr_d   = rspErr_q;
      rspValid_d = rspValid_q;
      grantVec   = '0;
      begComb    = 1'b0;
      ackComb    = 1'b0;

      case (state_q)
         IDLE: begin
            if (pickFound) begin
               grantVec[pickIdx] = 1'b1;
               gIdx_d            = pickIdx;
               opnd_d            = req_data[int'(pickIdx)*W +: W];
               op_d              = req_op[pickIdx];
               cnt_d             = '0;
               state_d           = START;
            end
         end

         START: begin
            begComb = 1'b1;
            state_d = WAIT;
         end

         WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cordic_ready) begin
               ackComb            = 1'b1;
               rspData_d          = cordic_result;
               rspErr_d           = 1'b0;
               rspValid_d         = '0;
               rspValid_d[gIdx_q] = 1'b1;
               state_d            = RESP;
            end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
               rspData_d          = '0;
               rspErr_d           = 1'b1;
               rspValid_d         = '0;
               rspValid_d[gIdx_q] = 1'b1;
               state_d            = RESP;
            end
         end

         RESP: begin
            if (rsp_ack[gIdx_q]) begin
               rspValid_d = '0;
               if (gIdx_q == IDXW'(NREQ - 1)) begin
                  ptr_d = '0;
               end else begin
                  ptr_d = gIdx_q + 1'b1;
               end
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any run in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         gIdx_q     <= '0;
         cnt_q      <= '0;
         opnd_q     <= '0;
         op_q       <= 1'b0;
         rspData_q  <= '0;
         rspErr_q   <= 1'b0;
         rspValid_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gIdx_q     <= gIdx_d;
         cnt_q      <= cnt_d;
         opnd_q     <= opnd_d;
         op_q       <= op_d;
         rspData_q  <= rspData_d;
         rspErr_q   <= rspErr_d;
         rspValid_q <= rspValid_d;
      end
   end

   // Grant is gated by reset so no pulse leaks out while reset is held.
   assign grant       = grantVec & {NREQ{reset}};
   assign rsp_valid   = rspValid_q;
   assign rsp_data    = rspData_q;
   assign rsp_err     = rspErr_q;
   assign cordic_beg  = begComb;
   assign cordic_data = opnd_q;
   assign cordic_op   = op_q;
   assign cordic_ack  = ackComb;
   assign busy        = (state_q != IDLE);

endmodule
